// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV64IM decode stage.
package riscv_pkg;

  typedef enum logic [5:0] {
    OP_NONE = 6'd0, OP_ILLEGAL,
    OP_ADD, OP_ADDW, OP_SUB, OP_SUBW, OP_XOR, OP_OR, OP_AND,
    OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
    OP_REM, OP_REMU, OP_REMW, OP_REMUW,
    OP_ADDI, OP_ADDIW, OP_SLTI, OP_ANDI, OP_XORI, OP_ORI,
    OP_SLLI, OP_SRLI, OP_SRAI, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_e;

  // major opcodes
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  // funct7 values; 64-bit shifts compare only the upper six bits
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [5:0] F6_BASE   = 6'b000000;
  localparam logic [5:0] F6_ALT    = 6'b010000;

  typedef struct packed {
    op_e         op;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } dec_rec_t;

endpackage

// File: rtl/riscv_insn_field_decode.sv
// Combinational crack of one 32-bit RV64IM word into a decoded record.
module riscv_insn_field_decode
  import riscv_pkg::*;
(
  input  logic [31:0] insn,
  output dec_rec_t    rec
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [5:0]  f6;
  op_e         op;
  logic        use_rs1, use_rs2;
  logic [31:0] imm;

  assign opc = insn[6:0];
  assign f3  = insn[14:12];
  assign f7  = insn[31:25];
  assign f6  = insn[31:26];

  // classify the word; anything not matched exactly stays illegal
  always_comb begin
    op      = OP_ILLEGAL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm     = '0;
    case (opc)
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case ({f7, f3})
          {F7_BASE,   3'b000}: op = OP_ADD;
          {F7_ALT,    3'b000}: op = OP_SUB;
          {F7_BASE,   3'b100}: op = OP_XOR;
          {F7_BASE,   3'b110}: op = OP_OR;
          {F7_BASE,   3'b111}: op = OP_AND;
          {F7_MULDIV, 3'b000}: op = OP_MUL;
          {F7_MULDIV, 3'b100}: op = OP_DIV;
          {F7_MULDIV, 3'b101}: op = OP_DIVU;
          {F7_MULDIV, 3'b110}: op = OP_REM;
          {F7_MULDIV, 3'b111}: op = OP_REMU;
          default:             op = OP_ILLEGAL;
        endcase
      end
      OP_REG32: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case ({f7, f3})
          {F7_BASE,   3'b000}: op = OP_ADDW;
          {F7_ALT,    3'b000}: op = OP_SUBW;
          {F7_MULDIV, 3'b000}: op = OP_MULW;
          {F7_MULDIV, 3'b100}: op = OP_DIVW;
          {F7_MULDIV, 3'b101}: op = OP_DIVUW;
          {F7_MULDIV, 3'b110}: op = OP_REMW;
          {F7_MULDIV, 3'b111}: op = OP_REMUW;
          default:             op = OP_ILLEGAL;
        endcase
      end
      OP_IMM: begin
        use_rs1 = 1'b1;
        imm     = {{20{insn[31]}}, insn[31:20]};
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            imm = {26'b0, insn[25:20]};
            if (f6 == F6_BASE) op = OP_SLLI;
          end
          3'b101: begin
            imm = {26'b0, insn[25:20]};
            if (f6 == F6_BASE)     op = OP_SRLI;
            else if (f6 == F6_ALT) op = OP_SRAI;
          end
          default: op = OP_ILLEGAL;
        endcase
      end
      OP_IMM32: begin
        use_rs1 = 1'b1;
        imm     = {{20{insn[31]}}, insn[31:20]};
        case (f3)
          3'b000: op = OP_ADDIW;
          // full funct7 match rejects shamt[5]=1 on W shifts
          3'b001: begin
            imm = {27'b0, insn[24:20]};
            if (f7 == F7_BASE) op = OP_SLLIW;
          end
          3'b101: begin
            imm = {27'b0, insn[24:20]};
            if (f7 == F7_BASE)     op = OP_SRLIW;
            else if (f7 == F7_ALT) op = OP_SRAIW;
          end
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_LUI: begin
        op  = OP_LUI;
        imm = {{12{insn[31]}}, insn[31:12]};
      end
      OPC_AUIPC: begin
        op  = OP_AUIPC;
        imm = {{12{insn[31]}}, insn[31:12]};
      end
      OPC_JAL: begin
        op  = OP_JAL;
        imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        imm     = {{20{insn[31]}}, insn[31:20]};
        if (f3 == 3'b000) op = OP_JALR;
      end
      default: op = OP_ILLEGAL;
    endcase
  end

  // assemble the record; illegal words carry no fields
  always_comb begin
    rec    = '0;
    rec.op = op;
    if (op == OP_ILLEGAL) begin
      rec.illegal = 1'b1;
    end else begin
      rec.rd  = {1'b0, insn[11:7]};
      rec.rs1 = use_rs1 ? {1'b0, insn[19:15]} : 6'd0;
      rec.rs2 = use_rs2 ? {1'b0, insn[24:20]} : 6'd0;
      rec.imm = imm;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode stage: output register + one-entry skid, end-of-program flag, counters.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output op_e              out_op,
  output logic [5:0]       out_rd,
  output logic [5:0]       out_rs1,
  output logic [5:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic             done,
  output logic [CNT_W-1:0] insn_count,
  output logic [15:0]      illegal_count
);

  dec_rec_t        dec, out_q, skid_q;
  logic [PC_W-1:0] out_pc_q, skid_pc_q;
  logic            out_v_q, skid_v_q, done_q, rdy_q;
  logic [CNT_W-1:0] icnt_q;
  logic [15:0]     ill_q;
  logic            acc, is_end, push, take, skid_v_n, done_n;

  riscv_insn_field_decode u_dec (.insn(in_insn), .rec(dec));

  assign acc      = in_valid && rdy_q;
  assign is_end   = acc && (in_insn == 32'h0);
  assign push     = acc && !is_end;
  assign take     = out_v_q && out_ready;
  // skid fills only when the output holds and is not drained; any take empties it
  assign skid_v_n = take ? 1'b0 : ((push && out_v_q) ? 1'b1 : skid_v_q);
  assign done_n   = done_q || is_end;

  // storage, handshake state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_pc_q  <= '0;
      skid_pc_q <= '0;
      out_v_q   <= 1'b0;
      skid_v_q  <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
      icnt_q    <= '0;
      ill_q     <= '0;
    end else begin
      // ready is registered so out_ready never reaches in_ready combinationally
      rdy_q    <= !skid_v_n && !done_n;
      done_q   <= done_n;
      skid_v_q <= skid_v_n;
      if (push && out_v_q && !take) begin
        skid_q    <= dec;
        skid_pc_q <= in_pc;
      end
      if (take && skid_v_q) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc_q;
      end else if (push && (!out_v_q || take)) begin
        out_q    <= dec;
        out_pc_q <= in_pc;
        out_v_q  <= 1'b1;
      end else if (take) begin
        out_v_q  <= 1'b0;
      end
      if (take) icnt_q <= icnt_q + CNT_W'(1);
      if (take && out_q.illegal && ill_q != 16'hFFFF) ill_q <= ill_q + 16'd1;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = out_v_q;
  assign out_op        = out_q.op;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_illegal   = out_q.illegal;
  assign out_pc        = out_pc_q;
  assign done          = done_q;
  assign insn_count    = icnt_q;
  assign illegal_count = ill_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage with a table-driven reference decoder.
module tb_riscv_decode_stage;
  import riscv_pkg::*;

  localparam int PC_W = 64, CNT_W = 32;

  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_insn = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic in_ready, out_valid, out_illegal, done;
  op_e out_op;
  logic [5:0] out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [PC_W-1:0] out_pc;
  logic [CNT_W-1:0] insn_count;
  logic [15:0] illegal_count;
  logic [120:0] obs;

  int n_cmp = 0, n_bad = 0;

  riscv_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .done(done),
    .insn_count(insn_count), .illegal_count(illegal_count));

  always #5 clk = ~clk;

  assign obs = {out_op, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal};

  typedef struct { op_e op; logic [5:0] rd, rs1, rs2; logic [31:0] imm; logic [63:0] pc; logic ill; } exp_t;
  typedef struct { logic [31:0] mask, match; op_e op; byte fmt; } pat_t;
  pat_t pats[$];

  localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F, MS = 32'hFC00707F, MU = 32'h0000007F;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'b0, f3, 5'b0, opc};
  endfunction

  function automatic void addp(input logic [31:0] mask, input logic [31:0] match, input op_e op, input byte fmt);
    pat_t p;
    p.mask = mask; p.match = match; p.op = op; p.fmt = fmt;
    pats.push_back(p);
  endfunction

  // one row per supported instruction: bits under mask must equal match
  function automatic void build_table();
    addp(MR, mk(7'h00, 3'd0, 7'h33), OP_ADD,   "R"); addp(MR, mk(7'h20, 3'd0, 7'h33), OP_SUB,  "R");
    addp(MR, mk(7'h00, 3'd4, 7'h33), OP_XOR,   "R"); addp(MR, mk(7'h00, 3'd6, 7'h33), OP_OR,   "R");
    addp(MR, mk(7'h00, 3'd7, 7'h33), OP_AND,   "R"); addp(MR, mk(7'h01, 3'd0, 7'h33), OP_MUL,  "R");
    addp(MR, mk(7'h01, 3'd4, 7'h33), OP_DIV,   "R"); addp(MR, mk(7'h01, 3'd5, 7'h33), OP_DIVU, "R");
    addp(MR, mk(7'h01, 3'd6, 7'h33), OP_REM,   "R"); addp(MR, mk(7'h01, 3'd7, 7'h33), OP_REMU, "R");
    addp(MR, mk(7'h00, 3'd0, 7'h3B), OP_ADDW,  "R"); addp(MR, mk(7'h20, 3'd0, 7'h3B), OP_SUBW, "R");
    addp(MR, mk(7'h01, 3'd0, 7'h3B), OP_MULW,  "R"); addp(MR, mk(7'h01, 3'd4, 7'h3B), OP_DIVW, "R");
    addp(MR, mk(7'h01, 3'd5, 7'h3B), OP_DIVUW, "R"); addp(MR, mk(7'h01, 3'd6, 7'h3B), OP_REMW, "R");
    addp(MR, mk(7'h01, 3'd7, 7'h3B), OP_REMUW, "R");
    addp(MI, mk(7'h00, 3'd0, 7'h13), OP_ADDI,  "I"); addp(MI, mk(7'h00, 3'd2, 7'h13), OP_SLTI, "I");
    addp(MI, mk(7'h00, 3'd4, 7'h13), OP_XORI,  "I"); addp(MI, mk(7'h00, 3'd6, 7'h13), OP_ORI,  "I");
    addp(MI, mk(7'h00, 3'd7, 7'h13), OP_ANDI,  "I");
    addp(MS, mk(7'h00, 3'd1, 7'h13), OP_SLLI,  "S"); addp(MS, mk(7'h00, 3'd5, 7'h13), OP_SRLI, "S");
    addp(MS, mk(7'h20, 3'd5, 7'h13), OP_SRAI,  "S");
    addp(MI, mk(7'h00, 3'd0, 7'h1B), OP_ADDIW, "I");
    addp(MR, mk(7'h00, 3'd1, 7'h1B), OP_SLLIW, "W"); addp(MR, mk(7'h00, 3'd5, 7'h1B), OP_SRLIW, "W");
    addp(MR, mk(7'h20, 3'd5, 7'h1B), OP_SRAIW, "W");
    addp(MU, 32'h37, OP_LUI, "U"); addp(MU, 32'h17, OP_AUIPC, "U"); addp(MU, 32'h6F, OP_JAL, "J");
    addp(MI, mk(7'h00, 3'd0, 7'h67), OP_JALR, "I");
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    e.op = OP_ILLEGAL; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.pc = pc; e.ill = 1'b1;
    foreach (pats[i]) begin
      if ((w & pats[i].mask) == pats[i].match) begin
        e.op = pats[i].op; e.ill = 1'b0; e.rd = {1'b0, w[11:7]};
        if (pats[i].fmt != "U" && pats[i].fmt != "J") e.rs1 = {1'b0, w[19:15]};
        if (pats[i].fmt == "R") e.rs2 = {1'b0, w[24:20]};
        if (pats[i].fmt == "I") e.imm = {{20{w[31]}}, w[31:20]};
        if (pats[i].fmt == "S") e.imm = {26'b0, w[25:20]};
        if (pats[i].fmt == "W") e.imm = {27'b0, w[24:20]};
        if (pats[i].fmt == "U") e.imm = {{12{w[31]}}, w[31:12]};
        if (pats[i].fmt == "J") e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
    end
    return e;
  endfunction

  function automatic logic [120:0] pkv(input op_e op, input logic [5:0] rd, input logic [5:0] rs1,
      input logic [5:0] rs2, input logic [31:0] imm, input logic [63:0] pc, input logic ill);
    return {op, rd, rs1, rs2, imm, pc, ill};
  endfunction

  function automatic logic [120:0] pk(input exp_t e);
    return pkv(e.op, e.rd, e.rs1, e.rs2, e.imm, e.pc, e.ill);
  endfunction

  function automatic logic [31:0] rand_legal();
    int k;
    k = $urandom_range(0, pats.size() - 1);
    return ($urandom & ~pats[k].mask) | pats[k].match;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if ({out_valid, in_ready, done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {out_valid, in_ready, done}); end
    n_cmp++; if (insn_count !== 0 || illegal_count !== 0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", insn_count, illegal_count); end
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", obs); end
    reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_addi();
    logic [120:0] want;
    do_reset();
    want = pkv(OP_ADDI, 6'd5, 6'd0, 6'd0, 32'hFFFFFFFF, 64'h100, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_insn = 32'hFFF00293; in_pc = 64'h100;
    tick(); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || obs !== want) begin n_bad++; $display("FAIL addi_rec got v=%b %h want 1 %h", out_valid, obs, want); end
    tick();
    n_cmp++; if (insn_count !== 1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_count got %0d v=%b want 1 v=0", insn_count, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [120:0] want[3];
    do_reset();
    w[0] = 32'h022081B3; w[1] = 32'h008000EF; w[2] = 32'h12345537;
    want[0] = pkv(OP_MUL, 6'd3, 6'd1, 6'd2, 32'h0, 64'h200, 1'b0);
    want[1] = pkv(OP_JAL, 6'd1, 6'd0, 6'd0, 32'h8, 64'h204, 1'b0);
    want[2] = pkv(OP_LUI, 6'd10, 6'd0, 6'd0, 32'h00012345, 64'h208, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_insn = w[i]; in_pc = 64'h200 + 64'(4 * i);
      tick();
      n_cmp++; if (out_valid !== 1'b1 || obs !== want[i]) begin n_bad++; $display("FAIL b2b_rec%0d got %h want %h", i, obs, want[i]); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (insn_count !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", insn_count); end
  endtask

  task automatic test_illegal();
    logic [31:0] w[2];
    do_reset();
    w[0] = 32'hFFFFFFFF; w[1] = 32'h0231109B;  // slliw with shamt bit 5 set
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_insn = w[i]; in_pc = 64'h300 + 64'(i);
      tick();
      n_cmp++; if (obs !== pkv(OP_ILLEGAL, 0, 0, 0, 0, 64'h300 + 64'(i), 1'b1)) begin n_bad++; $display("FAIL illegal_rec%0d got %h", i, obs); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (illegal_count !== 2 || insn_count !== 2) begin n_bad++; $display("FAIL illegal_count got %0d/%0d want 2/2", illegal_count, insn_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_insn = 32'hFFFFFFFF; in_pc = 0;
    repeat (65535) tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (illegal_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h want ffff", illegal_count); end
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
    n_cmp++; if (illegal_count !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", illegal_count); end
    n_cmp++; if (insn_count !== 65536) begin n_bad++; $display("FAIL sat_insn got %0d want 65536", insn_count); end
  endtask

  task automatic test_random_decode();
    int n_ill;
    exp_t e;
    logic [31:0] w;
    do_reset();
    n_ill = 0; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom % 4)
        0, 1: w = rand_legal();
        2: w = $urandom;
        default: w = rand_legal() ^ (32'h1 << $urandom_range(12, 31));
      endcase
      if (w == 0) w = 32'h1;
      e = ref_dec(w, {$urandom, $urandom});
      if (e.ill) n_ill++;
      in_valid = 1'b1; in_insn = w; in_pc = e.pc;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || obs !== pk(e)) begin n_bad++; $display("FAIL rdec insn=%h got %h want %h", w, obs, pk(e)); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (illegal_count !== 16'(n_ill) || insn_count !== 200) begin n_bad++; $display("FAIL rdec_counts got %0d/%0d want %0d/200", illegal_count, insn_count, n_ill); end
  endtask

  task automatic test_stream();
    logic [31:0] wd[100];
    logic [63:0] pcs[100];
    exp_t q[$];
    int sent, got, cyc;
    logic stall, acc, take;
    logic [120:0] held;
    do_reset();
    for (int i = 0; i < 100; i++) begin wd[i] = rand_legal(); pcs[i] = {$urandom, $urandom}; end
    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    while (got < 100 && cyc < 3000) begin
      if (sent < 100) begin in_valid = ($urandom % 4) != 0; in_insn = wd[sent]; in_pc = pcs[sent]; end
      else in_valid = 1'b0;
      out_ready = ($urandom % 3) != 0;
      n_cmp++; if (in_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL strm_ready cyc=%0d got %b occ=%0d", cyc, in_ready, q.size()); end
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL strm_valid cyc=%0d got %b occ=%0d", cyc, out_valid, q.size()); end
      if (stall) begin
        n_cmp++; if (obs !== held) begin n_bad++; $display("FAIL strm_stable cyc=%0d got %h want %h", cyc, obs, held); end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        n_cmp++; if (obs !== pk(q[0])) begin n_bad++; $display("FAIL strm_rec%0d got %h want %h", got, obs, pk(q[0])); end
      end
      acc = in_valid && in_ready;
      take = out_valid && out_ready;
      stall = out_valid && !out_ready;
      held = obs;
      tick(); cyc++;
      if (take && q.size() > 0) begin void'(q.pop_front()); got++; end
      if (acc) begin q.push_back(ref_dec(wd[sent], pcs[sent])); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (got !== 100) begin n_bad++; $display("FAIL strm_drain got %0d want 100", got); end
    n_cmp++; if (insn_count !== 100) begin n_bad++; $display("FAIL strm_count got %0d want 100", insn_count); end
  endtask

  task automatic test_end_of_program();
    logic [31:0] w[3];
    exp_t e[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin w[i] = rand_legal(); e[i] = ref_dec(w[i], 64'h400 + 64'(4 * i)); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_insn = w[0]; in_pc = e[0].pc; tick();
    in_insn = w[1]; in_pc = e[1].pc; tick(); in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || obs !== pk(e[0])) begin n_bad++; $display("FAIL eop_full rdy=%b got %h want %h", in_ready, obs, pk(e[0])); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || obs !== pk(e[1])) begin n_bad++; $display("FAIL eop_move rdy=%b got %h want %h", in_ready, obs, pk(e[1])); end
    in_valid = 1'b1; in_insn = w[2]; in_pc = e[2].pc; tick(); in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || obs !== pk(e[2])) begin n_bad++; $display("FAIL eop_third rdy=%b got %h want %h", in_ready, obs, pk(e[2])); end
    in_valid = 1'b1; in_insn = 32'h0; in_pc = 64'h40C; tick();
    n_cmp++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL eop_done got done=%b rdy=%b want 1/0", done, in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || obs !== pk(e[2])) begin n_bad++; $display("FAIL eop_hold got %h want %h", obs, pk(e[2])); end
    in_insn = w[0]; tick(); tick();
    n_cmp++; if (in_ready !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL eop_block got rdy=%b done=%b want 0/1", in_ready, done); end
    out_ready = 1'b1; tick();
    n_cmp++; if (out_valid !== 1'b0 || insn_count !== 3) begin n_bad++; $display("FAIL eop_drain got v=%b cnt=%0d want 0/3", out_valid, insn_count); end
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0 || insn_count !== 3 || done !== 1'b1) begin n_bad++; $display("FAIL eop_after got v=%b cnt=%0d done=%b", out_valid, insn_count, done); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_insn = 32'hFFFFFFFF; tick();
    in_insn = rand_legal(); tick();
    out_ready = 1'b0;
    in_insn = rand_legal(); tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || insn_count !== 1 || illegal_count !== 1) begin
      n_bad++; $display("FAIL mid_pre got v=%b rdy=%b cnt=%0d ill=%0d want 1/0/1/1", out_valid, in_ready, insn_count, illegal_count); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_flags got v=%b done=%b rdy=%b want 0/0/0", out_valid, done, in_ready); end
    n_cmp++; if (insn_count !== 0 || illegal_count !== 0) begin n_bad++; $display("FAIL mid_counts got %0d/%0d want 0/0", insn_count, illegal_count); end
    tick();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_random_decode();
    test_stream();
    test_end_of_program();
    test_reset_midstream();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
